// File: rtl/ascon_pkg.sv
// Shared definitions for the AEAD tag verifier: state encoding, tag length
// and the constant helper functions used to size counters.
package ascon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_FAIL    = 3'd4
  } state_e;

  localparam int TAG_LEN = 128;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to index v distinct values; never less than 1.
  function automatic int clog2_int(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_pt_buffer.sv
// Y-bit plaintext store written and read one bit at a time by index, with a
// zeroize input that wipes the whole buffer in one cycle.
module serial_pt_buffer
  import ascon_pkg::*;
#(
  parameter int Y  = 40,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_bit,
  input  logic [IW-1:0] rd_idx,
  input  logic          zeroize,
  output logic          rd_bit
);

  localparam int AW = clog2_int(Y);

  logic [Y-1:0]  mem;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign wr_addr = wr_idx[AW-1:0];
  assign rd_addr = rd_idx[AW-1:0];

  // NOTE: this storage is reset and zeroized on purpose so plaintext never
  // survives an aborted or failed verification.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '0;
    end else if (zeroize) begin
      mem <= '0;
    end else if (wr_en && (int'(wr_idx) < Y)) begin
      mem[wr_addr] <= wr_bit;
    end
  end

  assign rd_bit = (int'(rd_idx) < Y) ? mem[rd_addr] : 1'b0;

endmodule

// File: rtl/aead_tag_verifier.sv
// Serial AEAD tag verifier: buffers plaintext, compares computed and received
// tags bit-serially, releases plaintext only on a full match. Optional
// saturating failure counter under `TAG_FAIL_COUNT_EN.
module aead_tag_verifier
  import ascon_pkg::*;
#(
  parameter int Y = 40,
  parameter int T = TAG_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startxSI,
  input  logic       in_validxSI,
  input  logic       plain_textxSI,
  input  logic       tagxSI,
  input  logic       expected_tagxSI,
  output logic       plain_textxSO,
  output logic       plain_validxSO,
  output logic       tag_okxSO,
  output logic       donexSO,
  output logic       busyxSO
`ifdef TAG_FAIL_COUNT_EN
  ,
  output logic [7:0] fail_countxSO
`endif
);

  localparam int MAXL = max_int(Y, T);
  localparam int CW   = clog2_int(MAXL + 1);

  localparam logic [CW-1:0] Y_C    = CW'(Y);
  localparam logic [CW-1:0] T_C    = CW'(T);
  localparam logic [CW-1:0] LAST_C = CW'(MAXL - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mis_q, mis_d;
  logic          ok_q, ok_d;
  logic          pt_q, pt_d;
  logic          pv_q, pv_d;
  logic          done_q, done_d;
  logic          wr_en;
  logic          zeroize;
  logic          rd_bit;
  logic          fail_entry;

  serial_pt_buffer #(
    .Y  (Y),
    .IW (CW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (cnt_q),
    .wr_bit  (plain_textxSI),
    .rd_idx  (cnt_q),
    .zeroize (zeroize),
    .rd_bit  (rd_bit)
  );

  // NOTE: every signal gets a default first so no path leaves one unassigned
  // and infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mis_d      = mis_q;
    ok_d       = ok_q;
    pt_d       = 1'b0;
    pv_d       = 1'b0;
    done_d     = 1'b0;
    wr_en      = 1'b0;
    zeroize    = 1'b0;
    fail_entry = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A start coinciding with the done pulse belongs to the old run.
        if (startxSI && !done_q) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          mis_d   = 1'b0;
          ok_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        if (in_validxSI) begin
          wr_en = (cnt_q < Y_C);
          if (cnt_q < T_C) mis_d = mis_q | (tagxSI ^ expected_tagxSI);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_C) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        ok_d       = ~mis_q;
        cnt_d      = '0;
        fail_entry = mis_q;
        state_d    = mis_q ? ST_FAIL : ST_RELEASE;
      end
      ST_RELEASE: begin
        if (cnt_q < Y_C) begin
          pv_d  = 1'b1;
          pt_d  = rd_bit;
          cnt_d = cnt_q + 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_FAIL: begin
        done_d  = 1'b1;
        ok_d    = 1'b0;
        zeroize = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      ok_q    <= 1'b0;
      pt_q    <= 1'b0;
      pv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      ok_q    <= ok_d;
      pt_q    <= pt_d;
      pv_q    <= pv_d;
      done_q  <= done_d;
    end
  end

  assign plain_textxSO  = pt_q;
  assign plain_validxSO = pv_q;
  assign tag_okxSO      = ok_q;
  assign donexSO        = done_q;
  assign busyxSO        = (state_q != ST_IDLE);

`ifdef TAG_FAIL_COUNT_EN
  logic [7:0] fail_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_cnt_q <= '0;
    end else if (fail_entry && (fail_cnt_q != 8'hFF)) begin
      fail_cnt_q <= fail_cnt_q + 8'd1;
    end
  end

  assign fail_countxSO = fail_cnt_q;
`else
  logic unused_fail_entry;
  assign unused_fail_entry = fail_entry;
`endif

endmodule
